// File: rtl/irq_source_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : irq_source_arbiter_if
// Purpose   : Groups the source lines, enables and the controller handshake.
// Revision  : 1.0 - initial release
// ============================================================================
interface irq_source_arbiter_if #(
    parameter int N_SRC = 8
);
    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] irq_src_i;
    logic [N_SRC-1:0] irq_en_i;
    logic             irq_taken_i;
    logic             irq_ret_i;
    logic             irq_req_o;
    logic [31:0]      irq_cause_o;
    logic [N_SRC-1:0] irq_ack_o;
    logic [ID_W-1:0]  cur_id_o;
    logic             busy_o;

    modport master (
        output irq_src_i, irq_en_i, irq_taken_i, irq_ret_i,
        input  irq_req_o, irq_cause_o, irq_ack_o, cur_id_o, busy_o
    );

    modport slave (
        input  irq_src_i, irq_en_i, irq_taken_i, irq_ret_i,
        output irq_req_o, irq_cause_o, irq_ack_o, cur_id_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/irq_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : irq_source_arbiter
// Purpose   : Latches one pending enabled interrupt source, requests the
//             controller and holds the selection until return from trap.
// Option    : IRQ_ROUND_ROBIN_EN selects rotating instead of fixed priority.
// Revision  : 1.0 - initial release
// ============================================================================
module irq_source_arbiter #(
    parameter int               N_SRC      = 8,
    parameter logic [N_SRC-1:0] EDGE_MASK  = {N_SRC{1'b0}},
    parameter logic [31:0]      CAUSE_BASE = 32'h1000_0010
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    irq_source_arbiter_if.slave bus
);
    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [31:0]      cause_q, cause_d;
    logic [N_SRC-1:0] meta_q, sync_q;
    logic [N_SRC-1:0] w_pend, w_cand, w_ack, w_onehot;
    logic [ID_W-1:0]  w_pick;

    function automatic logic [ID_W-1:0] lowest(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if ((v & (N_SRC'(1) << k)) != '0) r = ID_W'(k);
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= bus.irq_src_i;
            sync_q <= meta_q;
        end
    end

    // Edge sources keep a sticky pending bit; a new rise beats the accept clear.
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        if (EDGE_MASK[k]) begin : g_edge
            logic prev_q, pend_q, pend_d;
            assign pend_d = (sync_q[k] & ~prev_q) | (pend_q & ~w_ack[k]);
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    prev_q <= 1'b0;
                    pend_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[k];
                    pend_q <= pend_d;
                end
            end
            assign w_pend[k] = pend_q;
        end else begin : g_level
            assign w_pend[k] = sync_q[k];
        end
    end

    assign w_cand   = w_pend & bus.irq_en_i;
    assign w_onehot = N_SRC'(1) << id_q;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic [ID_W:0] N_SRC_W = (ID_W + 1)'(N_SRC);

    logic [ID_W-1:0]  last_q, last_d, w_start;
    logic [N_SRC-1:0] w_rot;
    logic [ID_W:0]    w_sum;

    assign w_start = (last_q == ID_W'(N_SRC - 1)) ? '0 : last_q + ID_W'(1);
    assign w_rot   = N_SRC'({w_cand, w_cand} >> w_start);
    assign w_sum   = {1'b0, w_start} + {1'b0, lowest(w_rot)};
    assign w_pick  = (w_sum >= N_SRC_W) ? ID_W'(w_sum - N_SRC_W) : ID_W'(w_sum);
    assign last_d  = (w_ack != '0) ? id_q : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= ID_W'(N_SRC - 1);
        else         last_q <= last_d;
    end
`else
    assign w_pick = lowest(w_cand);
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cause_d = cause_q;
        w_ack   = '0;
        case (state_q)
            S_IDLE: begin
                if (w_cand != '0) begin
                    id_d    = w_pick;
                    cause_d = CAUSE_BASE + 32'(w_pick);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.irq_taken_i) begin
                    w_ack   = w_onehot;
                    state_d = S_SERVICE;
                end else if ((w_cand & w_onehot) == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (bus.irq_ret_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            cause_q <= CAUSE_BASE;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cause_q <= cause_d;
        end
    end

    assign bus.irq_req_o   = (state_q == S_REQ);
    assign bus.irq_cause_o = cause_q;
    assign bus.irq_ack_o   = w_ack;
    assign bus.cur_id_o    = id_q;
    assign bus.busy_o      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_irq_source_arbiter.sv
`timescale 1ns/1ps
// Bench for irq_source_arbiter: directed scenarios plus randomized traffic
// checked against a priority-pick reference model.
module tb_irq_source_arbiter;
    localparam int          N     = 8;
    localparam int          IDW   = 3;
    localparam logic [N-1:0] EMASK = 8'h03;
    localparam logic [31:0] CBASE = 32'h1000_0010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    irq_source_arbiter_if #(.N_SRC(N)) bus ();

    irq_source_arbiter #(
        .N_SRC      (N),
        .EDGE_MASK  (EMASK),
        .CAUSE_BASE (CBASE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.irq_req_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] p, input int last);
`ifdef IRQ_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (last + i) % N;
            if (p[j]) return j;
        end
`else
        for (int i = 0; i < N; i++) if (p[i]) return i;
`endif
        return -1;
    endfunction

    // Accept the current request, check the ack, and return from the trap.
    task automatic serve(input int id, input bit drop_level);
        logic [N-1:0] e_ack;
        e_ack = N'(1) << id;
        bus.irq_taken_i = 1'b1;
        #1;
        checks++;
        if (bus.irq_ack_o !== e_ack) begin
            errors++;
            $display("FAIL serve_ack: got %h expected %h", bus.irq_ack_o, e_ack);
        end
        step();
        bus.irq_taken_i = 1'b0;
        if (drop_level) bus.irq_src_i[id] = 1'b0;
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.irq_ack_o !== '0) begin
            errors++;
            $display("FAIL serve_service: req %b busy %b ack %h expected 0 1 00",
                     bus.irq_req_o, bus.busy_o, bus.irq_ack_o);
        end
        steps(4);
        bus.irq_ret_i = 1'b1;
        step();
        bus.irq_ret_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL serve_ret_busy: got %b expected 0", bus.busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        steps(2);
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.irq_ack_o !== '0 ||
            bus.cur_id_o !== '0 || bus.irq_cause_o !== CBASE) begin
            errors++;
            $display("FAIL reset_state: req %b busy %b ack %h id %0d cause %h expected 0 0 00 0 %h",
                     bus.irq_req_o, bus.busy_o, bus.irq_ack_o, bus.cur_id_o, bus.irq_cause_o, CBASE);
        end
        rst_n = 1'b1;
        steps(3);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b req %b expected 0 0", bus.busy_o, bus.irq_req_o);
        end
    endtask

    task automatic test_level_latency();
        bus.irq_src_i[3] = 1'b1;
        steps(2);
        checks++;
        if (bus.irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL level_early_req: got %b expected 0", bus.irq_req_o);
        end
        step();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_cause_o !== 32'h1000_0013 || bus.cur_id_o !== 3'd3) begin
            errors++;
            $display("FAIL level_req: req %b cause %h id %0d expected 1 10000013 3",
                     bus.irq_req_o, bus.irq_cause_o, bus.cur_id_o);
        end
        serve(3, 1'b1);
    endtask

    task automatic test_reset_mid_service();
        bit got;
        bus.irq_src_i[6] = 1'b1;
        wait_req(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_mid_req_timeout: got no request expected request");
        end
        bus.irq_taken_i = 1'b1;
        step();
        bus.irq_taken_i = 1'b0;
        bus.irq_src_i   = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.irq_ack_o !== '0 ||
            bus.irq_cause_o !== CBASE) begin
            errors++;
            $display("FAIL rst_mid_outputs: req %b busy %b ack %h cause %h expected 0 0 00 %h",
                     bus.irq_req_o, bus.busy_o, bus.irq_ack_o, bus.irq_cause_o, CBASE);
        end
        step();
        rst_n = 1'b1;
        steps(4);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy %b expected 0", bus.busy_o);
        end
    endtask

    task automatic test_edge_src1();
        bit got;
        bus.irq_src_i[1] = 1'b1;
        step();
        bus.irq_src_i[1] = 1'b0;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0011) begin
            errors++;
            $display("FAIL edge1_req: got %b cause %h expected 1 10000011", got, bus.irq_cause_o);
        end
        bus.irq_taken_i = 1'b1;
        #1;
        checks++;
        if (bus.irq_ack_o !== 8'h02) begin
            errors++;
            $display("FAIL edge1_ack: got %h expected 02", bus.irq_ack_o);
        end
        step();
        bus.irq_taken_i  = 1'b0;
        bus.irq_src_i[1] = 1'b1;
        step();
        bus.irq_src_i[1] = 1'b0;
        steps(4);
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL edge1_hold: req %b busy %b expected 0 1", bus.irq_req_o, bus.busy_o);
        end
        bus.irq_ret_i = 1'b1;
        step();
        bus.irq_ret_i = 1'b0;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0011) begin
            errors++;
            $display("FAIL edge1_rereq: got %b cause %h expected 1 10000011", got, bus.irq_cause_o);
        end
        serve(1, 1'b0);
    endtask

    task automatic test_priority();
        bit got;
        bus.irq_src_i[2] = 1'b1;
        bus.irq_src_i[5] = 1'b1;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0012 || bus.cur_id_o !== 3'd2) begin
            errors++;
            $display("FAIL prio_first: got %b cause %h id %0d expected 1 10000012 2",
                     got, bus.irq_cause_o, bus.cur_id_o);
        end
        serve(2, 1'b1);
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0015 || bus.cur_id_o !== 3'd5) begin
            errors++;
            $display("FAIL prio_second: got %b cause %h id %0d expected 1 10000015 5",
                     got, bus.irq_cause_o, bus.cur_id_o);
        end
        serve(5, 1'b1);
    endtask

    task automatic test_mask_drop();
        bit got;
        bus.irq_src_i[4] = 1'b1;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0014) begin
            errors++;
            $display("FAIL mask_req: got %b cause %h expected 1 10000014", got, bus.irq_cause_o);
        end
        bus.irq_en_i[4] = 1'b0;
        step();
        checks++;
        if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.irq_ack_o !== '0) begin
            errors++;
            $display("FAIL mask_drop: req %b busy %b ack %h expected 0 0 00",
                     bus.irq_req_o, bus.busy_o, bus.irq_ack_o);
        end
        bus.irq_src_i[4] = 1'b0;
        steps(4);
        bus.irq_en_i = '1;
        steps(3);
        checks++;
        if (bus.irq_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mask_quiet: req %b expected 0", bus.irq_req_o);
        end
    endtask

    task automatic test_edge_in_accept();
        bit got;
        bus.irq_src_i[0] = 1'b1;
        step();
        bus.irq_src_i[0] = 1'b0;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0010) begin
            errors++;
            $display("FAIL edge0_req: got %b cause %h expected 1 10000010", got, bus.irq_cause_o);
        end
        // Time the second rise to land in the same cycle as the accept.
        bus.irq_src_i[0] = 1'b1;
        step();
        bus.irq_src_i[0] = 1'b0;
        step();
        bus.irq_taken_i = 1'b1;
        #1;
        checks++;
        if (bus.irq_ack_o !== 8'h01) begin
            errors++;
            $display("FAIL edge0_ack: got %h expected 01", bus.irq_ack_o);
        end
        step();
        bus.irq_taken_i = 1'b0;
        steps(3);
        bus.irq_ret_i = 1'b1;
        step();
        bus.irq_ret_i = 1'b0;
        wait_req(got);
        checks++;
        if (!got || bus.irq_cause_o !== 32'h1000_0010) begin
            errors++;
            $display("FAIL edge0_rereq: got %b cause %h expected 1 10000010", got, bus.irq_cause_o);
        end
        serve(0, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] m_edge, m_level, en_r, pulses, pend, e_ack;
        logic [IDW-1:0] e_id;
        int m_last, exp;
        bit got;
        rst_n = 1'b0;
        step();
        rst_n  = 1'b1;
        m_edge = '0;
        m_last = N - 1;
        for (int it = 0; it < 16; it++) begin
            bus.irq_en_i = '0;
            m_level = N'($urandom) & ~EMASK;
            pulses  = N'($urandom) & EMASK;
            bus.irq_src_i = m_level | pulses;
            step();
            bus.irq_src_i = m_level;
            m_edge = m_edge | pulses;
            steps(5);
            checks++;
            if (bus.irq_req_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd_masked_req: iter %0d req %b expected 0", it, bus.irq_req_o);
            end
            en_r = N'($urandom);
            bus.irq_en_i = en_r;
            for (int n = 0; n < N + 2; n++) begin
                pend = (m_edge | m_level) & en_r;
                if (pend == '0) break;
                exp  = model_pick(pend, m_last);
                e_id = exp[IDW-1:0];
                e_ack = N'(1) << exp;
                wait_req(got);
                checks++;
                if (!got || bus.cur_id_o !== e_id || bus.irq_cause_o !== CBASE + 32'(exp)) begin
                    errors++;
                    $display("FAIL rnd_pick: iter %0d got %b id %0d cause %h expected id %0d cause %h",
                             it, got, bus.cur_id_o, bus.irq_cause_o, exp, CBASE + 32'(exp));
                    break;
                end
                bus.irq_taken_i = 1'b1;
                #1;
                checks++;
                if (bus.irq_ack_o !== e_ack) begin
                    errors++;
                    $display("FAIL rnd_ack: iter %0d got %h expected %h", it, bus.irq_ack_o, e_ack);
                end
                step();
                bus.irq_taken_i = 1'b0;
                if (EMASK[exp]) m_edge[exp] = 1'b0;
                else begin
                    m_level[exp] = 1'b0;
                    bus.irq_src_i[exp] = 1'b0;
                end
                m_last = exp;
                steps(4);
                bus.irq_ret_i = 1'b1;
                step();
                bus.irq_ret_i = 1'b0;
            end
            steps(3);
            checks++;
            if (bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rnd_drained: iter %0d req %b busy %b expected 0 0",
                         it, bus.irq_req_o, bus.busy_o);
            end
            bus.irq_en_i  = '0;
            bus.irq_src_i = '0;
            steps(4);
        end
    endtask

    initial begin
        bus.irq_src_i   = '0;
        bus.irq_en_i    = '1;
        bus.irq_taken_i = 1'b0;
        bus.irq_ret_i   = 1'b0;
        test_reset();
        test_level_latency();
        test_reset_mid_service();
        test_edge_src1();
        test_priority();
        test_mask_drop();
        test_edge_in_accept();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
